tx_serializer: RTL and testbench
================================

// Module: tx_serializer
// PURPOSE
//  Parallel-to-serial stage directly downstream of the TX controller.
//  - Accepts one serial_frame_t (bus_pkg) per start request.
//  - Shifts it out MSB-first on a single line at CLKS_PER_BIT clocks per bit.
//  - Reports busy/done back to the controller; sits between the controller and the bus line.
// PARAMETERS
//  CLKS_PER_BIT  4  clk_i cycles per serial bit; legal range >=1 (1 = one bit per clock)
//  GUARD_BITS    2  idle-high bit-times after the stop bit; used only with TX_SER_GUARD_EN
// PORTS
//  clk_i        in   1        single clock; all logic on posedge
//  rst_ni       in   1        asynchronous, active-low reset
//  ser_start_i  in   1        level request; sampled only in S_IDLE
//  ser_frame_i  in   FRAME_W  frame to send; FRAME_W = $bits(serial_frame_t); captured at start
//  ser_busy_o   out  1        high while shifting (and guarding); registered
//  ser_done_o   out  1        one-cycle pulse after the last bit-time; registered
//  tx_o         out  1        serial line; idle high; registered
// BEHAVIOUR
//  Reset (async, any state): state=S_IDLE; ser_busy_o=0; ser_done_o=0; tx_o=1; counters=0.
//  FSM:
//  - S_IDLE: ser_start_i=1 at edge N -> latch ser_frame_i to shift reg, bit_cnt=0, clk_cnt=0,
//    go S_SHIFT. From cycle N+1: ser_busy_o=1, tx_o=frame[FRAME_W-1] (start field, MSB).
//  - S_SHIFT: clk_cnt counts 0..CLKS_PER_BIT-1; at terminal count shift left, clk_cnt=0,
//    bit_cnt++.
//    - After the bit_cnt=FRAME_W-1 period -> S_DONE, or S_GUARD when the macro is on.
//    - tx_o always equals the current shift-reg MSB.
//  - S_GUARD: tx_o=1, busy=1 for GUARD_BITS*CLKS_PER_BIT cycles -> S_DONE.
//  - S_DONE: ser_done_o=1 and ser_busy_o=0 for exactly one cycle, tx_o=1 -> S_IDLE.
//  Timing:
//  - ser_busy_o high exactly FRAME_W*CLKS_PER_BIT cycles, plus guard time when enabled.
//  - ser_done_o rises the cycle busy falls.
//  - Minimum start-to-start spacing: busy time +2 cycles.
//  Handshake rules:
//  - ser_start_i is level-sensitive and ignored outside S_IDLE.
//  - Start still high in the S_IDLE cycle after S_DONE starts a new frame. Upstream must
//    drop start once busy is seen.
//  - ser_frame_i changes after the capture edge have no effect on the current frame.
//  Widths:
//  - clk_cnt is $clog2(CLKS_PER_BIT+1) bits; bit_cnt is $clog2(FRAME_W+1) bits.
//  - No wrap: counters are cleared on every state entry.
//  Boundaries:
//  - CLKS_PER_BIT=1: one bit per clock, no idle gaps between bits.
//  - Start asserted in the same cycle reset deasserts: sampled at the first active edge.
//  - Reset mid-frame: tx_o=1 immediately; no done pulse; the partial frame is discarded.
//  - Illegal state encoding: return to S_IDLE with outputs at their reset values.
// CONFIGURATION
//  TX_SER_GUARD_EN defined:
//  - S_GUARD is inserted after the stop bit (GUARD_BITS idle-high bit-times, busy held).
//  - ser_done_o fires after the guard time.
//  TX_SER_GUARD_EN undefined:
//  - No S_GUARD; S_SHIFT goes straight to S_DONE; GUARD_BITS is ignored.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  T1 Frame send:
//  - Stimulus: start=1 for 1 cycle, frame={start=1, cmd=CMD_WRITE, addr=0x0012, data=0xA5,
//    parity, stop=1}.
//  - Required: tx_o reproduces the frame MSB-first, each bit held 4 clk; busy high
//    FRAME_W*4 cycles; single done pulse.
//  T2 Level start:
//  - Stimulus: start held high until busy, frame changed to data=0x5A mid-shift.
//  - Required: exactly one frame sent, carrying data=0xA5; start ignored while busy.
//  T3 Back-to-back:
//  - Stimulus: start high through S_DONE.
//  - Required: second frame begins on the S_IDLE cycle; tx_o high for exactly 2 cycles
//    between stop bit and next start bit.
//  T4 CLKS_PER_BIT=1:
//  - Stimulus: frame of alternating bits.
//  - Required: tx_o toggles every clock; busy = FRAME_W cycles.
//  T5 Reset mid-frame:
//  - Stimulus: rst_ni low at bit 7.
//  - Required: tx_o=1, busy=0, done=0 asynchronously; no done pulse afterwards; next start
//    sends a full clean frame.
//  T6 Guard (TX_SER_GUARD_EN, GUARD_BITS=2):
//  - Required: 8 extra cycles with tx_o=1 and busy=1 after the stop bit, then done.

Source files
------------

// File: rtl/tx_serializer.sv
// ---------------------------------------------------------------------------
// bus_pkg + tx_serializer
//
// Purpose:
//   This is the parallel-to-serial stage that sits behind the TX controller.
//   - On a start request it captures one serial_frame_t.
//   - It shifts the frame out MSB-first on tx_o, holding each bit for
//     CLKS_PER_BIT clocks.
//   - ser_busy_o is high while the frame is on the line.
//   - ser_done_o pulses for one cycle once the frame is complete.
//
// Optional feature (compile-time macro TX_SER_GUARD_EN):
//   - When the macro is defined, GUARD_BITS idle-high bit-times follow the
//     stop bit, and busy stays high during them.
//   - The done pulse then comes after the guard time.
//   - When the macro is undefined, the frame ends directly in S_DONE and
//     GUARD_BITS is ignored.
//
// Parameters:
//   CLKS_PER_BIT  clk_i cycles per serial bit (>= 1)
//   GUARD_BITS    idle-high bit-times after the stop bit (guard build only)
//
// Ports:
//   clk_i        in   single clock, posedge
//   rst_ni       in   asynchronous active-low reset
//   ser_start_i  in   level start request, honoured only in S_IDLE
//   ser_frame_i  in   frame to send, captured on the start edge
//   ser_busy_o   out  high while shifting (and guarding), registered
//   ser_done_o   out  one-cycle pulse after the last bit-time, registered
//   tx_o         out  serial line, idle high, registered
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  // Field order is transmission order: start goes out first, stop goes out last.
  // parity is even parity over {cmd, addr, data}; the controller computes it.
  typedef struct packed {
    logic        start;
    cmd_e        cmd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        parity;
    logic        stop;
  } serial_frame_t;

endpackage

module tx_serializer
  import bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int GUARD_BITS   = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ser_start_i,
  input  serial_frame_t ser_frame_i,
  output logic          ser_busy_o,
  output logic          ser_done_o,
  output logic          tx_o
);

  localparam int FRAME_W = $bits(serial_frame_t);
  localparam int CW      = $clog2(CLKS_PER_BIT + 1);
  localparam int BW      = $clog2(FRAME_W + 1);

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);

`ifdef TX_SER_GUARD_EN
  // The +2 keeps the width at least 1 bit, even when GUARD_BITS is 0.
  localparam int              GW         = $clog2(GUARD_BITS + 2);
  localparam logic [GW-1:0]   GUARD_LAST = GW'(GUARD_BITS - 1);
`else
  logic unused_guard_bits;
  assign unused_guard_bits = ^GUARD_BITS;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef TX_SER_GUARD_EN
    ,
    S_GUARD = 2'd3
`endif
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       clk_cnt_q;
  logic [BW-1:0]       bit_cnt_q;
`ifdef TX_SER_GUARD_EN
  logic [GW-1:0]       guard_cnt_q;
`endif

  // rest_q holds the bits that still have to go out after the one now on tx_o.
  // The bit being sent lives only in the registered tx_o, so the shifter is
  // one bit narrower than the frame.
  logic [FRAME_W-2:0]  rest_q;

  logic clk_last;
  logic bit_last;
  logic ld_en;
  logic sh_en;

  assign clk_last = (clk_cnt_q == CLK_LAST);
  assign bit_last = (bit_cnt_q == BIT_LAST);
  assign ld_en    = (state_q == S_IDLE) && ser_start_i;
  assign sh_en    = (state_q == S_SHIFT) && clk_last && !bit_last;

  // Data path: the shift register is reloaded on every start, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (ld_en) begin
      rest_q <= ser_frame_i[FRAME_W-2:0];
    end else if (sh_en) begin
      rest_q <= {rest_q[FRAME_W-3:0], 1'b1};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
`ifdef TX_SER_GUARD_EN
      guard_cnt_q <= '0;
`endif
      ser_busy_o  <= 1'b0;
      ser_done_o  <= 1'b0;
      tx_o        <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          ser_done_o <= 1'b0;
          clk_cnt_q  <= '0;
          bit_cnt_q  <= '0;
          if (ser_start_i) begin
            state_q    <= S_SHIFT;
            ser_busy_o <= 1'b1;
            tx_o       <= ser_frame_i[FRAME_W-1];
          end else begin
            ser_busy_o <= 1'b0;
            tx_o       <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (!clk_last) begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end else if (!bit_last) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= bit_cnt_q + BW'(1);
            tx_o      <= rest_q[FRAME_W-2];
          end else begin
            // The stop bit has been on the line for its full bit-time.
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_o      <= 1'b1;
`ifdef TX_SER_GUARD_EN
            if (GUARD_BITS > 0) begin
              state_q     <= S_GUARD;
              guard_cnt_q <= '0;
            end else begin
              state_q    <= S_DONE;
              ser_busy_o <= 1'b0;
              ser_done_o <= 1'b1;
            end
`else
            state_q    <= S_DONE;
            ser_busy_o <= 1'b0;
            ser_done_o <= 1'b1;
`endif
          end
        end

`ifdef TX_SER_GUARD_EN
        S_GUARD: begin
          // The line stays idle-high; clk_cnt times one bit, guard_cnt counts bit-times.
          tx_o <= 1'b1;
          if (!clk_last) begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end else if (guard_cnt_q != GUARD_LAST) begin
            clk_cnt_q   <= '0;
            guard_cnt_q <= guard_cnt_q + GW'(1);
          end else begin
            clk_cnt_q   <= '0;
            guard_cnt_q <= '0;
            state_q     <= S_DONE;
            ser_busy_o  <= 1'b0;
            ser_done_o  <= 1'b1;
          end
        end
`endif

        S_DONE: begin
          state_q    <= S_IDLE;
          clk_cnt_q  <= '0;
          bit_cnt_q  <= '0;
          ser_busy_o <= 1'b0;
          ser_done_o <= 1'b0;
          tx_o       <= 1'b1;
        end

        default: begin
          // Unreachable encoding: fall back to the reset condition.
          state_q    <= S_IDLE;
          clk_cnt_q  <= '0;
          bit_cnt_q  <= '0;
          ser_busy_o <= 1'b0;
          ser_done_o <= 1'b0;
          tx_o       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// ---------------------------------------------------------------------------
// Testbench for tx_serializer.
//   - u_dut0 runs with CLKS_PER_BIT=4.
//   - u_dut1 runs with CLKS_PER_BIT=1.
//   - Both use GUARD_BITS=2.
// The expected frame words are hand-computed 29-bit constants.
// ---------------------------------------------------------------------------
module tb_tx_serializer;
  import bus_pkg::*;

  localparam int FW = 29;

`ifdef TX_SER_GUARD_EN
  localparam int G0 = 2 * 4;
  localparam int G1 = 2 * 1;
`else
  localparam int G0 = 0;
  localparam int G1 = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start0, start1;
  serial_frame_t frame0, frame1;
  logic          busy0, done0, tx0;
  logic          busy1, done1, tx1;

  int checks;
  int failures;

  tx_serializer #(.CLKS_PER_BIT(4), .GUARD_BITS(2)) u_dut0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ser_start_i(start0),
    .ser_frame_i(frame0),
    .ser_busy_o (busy0),
    .ser_done_o (done0),
    .tx_o       (tx0)
  );

  tx_serializer #(.CLKS_PER_BIT(1), .GUARD_BITS(2)) u_dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ser_start_i(start1),
    .ser_frame_i(frame1),
    .ser_busy_o (busy1),
    .ser_done_o (done1),
    .tx_o       (tx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        par;
    int          hold;
    logic [7:0]  alt_data;
    logic [28:0] exp_word;
    string       name;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk_vec(input int sel, input logic [1:0] cmd, input logic [15:0] addr,
                                  input logic [7:0] data, input logic par, input int hold,
                                  input logic [7:0] alt_data, input logic [28:0] exp_word,
                                  input string name);
    vec_t v;
    v.sel = sel; v.cmd = cmd; v.addr = addr; v.data = data; v.par = par;
    v.hold = hold; v.alt_data = alt_data; v.exp_word = exp_word; v.name = name;
    return v;
  endfunction

  function automatic serial_frame_t mk_frame(input logic [1:0] cmd, input logic [15:0] addr,
                                             input logic [7:0] data, input logic par);
    serial_frame_t f;
    f.start  = 1'b1;
    f.cmd    = cmd_e'(cmd);
    f.addr   = addr;
    f.data   = data;
    f.parity = par;
    f.stop   = 1'b1;
    return f;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_frame(input int sel, input serial_frame_t f);
    if (sel == 0) frame0 = f; else frame1 = f;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Called at the negedge of the first busy cycle. The task samples one tx bit per clock
  // until busy drops. Start stays high (with frame = alt) for the first `hold` busy cycles.
  task automatic collect(input int sel, input int cpb, input int gcyc, input logic [28:0] exp,
                         input string nm, input int hold, input serial_frame_t alt);
    logic        smp[256];
    int          n;
    int          done_early;
    int          unstable;
    int          guard_bad;
    logic [28:0] got;
    n = 0; done_early = 0; unstable = 0; guard_bad = 0; got = '0;
    for (int i = 0; i < 256; i++) smp[i] = 1'bx;
    while (get_busy(sel) && n < 256) begin
      smp[n] = get_tx(sel);
      if (get_done(sel)) done_early++;
      if (n < hold) begin
        set_start(sel, 1'b1);
        set_frame(sel, alt);
      end else begin
        set_start(sel, 1'b0);
      end
      n++;
      @(negedge clk);
    end
    set_start(sel, 1'b0);
    chk({nm, "_busy_len"}, 32'(n), 32'(FW * cpb + gcyc));
    for (int b = 0; b < FW; b++) got[FW-1-b] = smp[b * cpb];
    for (int i = 0; i < FW * cpb; i++)
      if (smp[i] !== smp[(i / cpb) * cpb]) unstable++;
    chk({nm, "_word"}, 32'(got), 32'(exp));
    chk({nm, "_bit_hold"}, 32'(unstable), 32'd0);
    chk({nm, "_done_while_busy"}, 32'(done_early), 32'd0);
    if (gcyc > 0) begin
      for (int i = FW * cpb; i < FW * cpb + gcyc; i++)
        if (smp[i] !== 1'b1) guard_bad++;
      chk({nm, "_guard_high"}, 32'(guard_bad), 32'd0);
    end
    chk({nm, "_done_pulse"}, 32'(get_done(sel)), 32'd1);
    chk({nm, "_done_tx"}, 32'(get_tx(sel)), 32'd1);
    @(negedge clk);
    chk({nm, "_done_clear"}, 32'(get_done(sel)), 32'd0);
    chk({nm, "_idle_busy"}, 32'(get_busy(sel)), 32'd0);
    @(negedge clk);
    chk({nm, "_no_restart"}, 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic run_frame(input int sel, input serial_frame_t f, input int cpb, input int gcyc,
                           input logic [28:0] exp, input string nm, input int hold,
                           input serial_frame_t alt);
    set_frame(sel, f);
    set_start(sel, 1'b1);
    @(negedge clk);
    chk({nm, "_start_lat"}, 32'(get_busy(sel)), 32'd1);
    collect(sel, cpb, gcyc, exp, nm, hold, alt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    serial_frame_t f, alt, fz;
    int            gap, dcnt, bcnt;
    checks = 0; failures = 0;

    vecs[0] = mk_vec(0, 2'b01, 16'h0012, 8'hA5, 1'b1, 0, 8'hA5, 29'h14004A97, "t1_write");
    vecs[1] = mk_vec(0, 2'b01, 16'h0012, 8'hA5, 1'b1, 6, 8'h5A, 29'h14004A97, "t2_level");
    vecs[2] = mk_vec(0, 2'b10, 16'hFFFF, 8'h00, 1'b1, 0, 8'h00, 29'h1BFFFC03, "read_ffff");
    vecs[3] = mk_vec(0, 2'b00, 16'h0000, 8'h00, 1'b0, 0, 8'h00, 29'h10000001, "zeros");
    vecs[4] = mk_vec(1, 2'b01, 16'h5555, 8'h55, 1'b0, 0, 8'h55, 29'h15555555, "t4_alt_cpb1");
    vecs[5] = mk_vec(1, 2'b01, 16'h0012, 8'hA5, 1'b1, 0, 8'hA5, 29'h14004A97, "write_cpb1");

    fz = mk_frame(2'b00, 16'h0000, 8'h00, 1'b0);

    // Reset values; start0 is already high so it is seen on the first edge after release.
    rst_n  = 1'b0;
    start0 = 1'b1;
    start1 = 1'b0;
    frame0 = fz;
    frame1 = fz;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx0", 32'(tx0), 32'd1);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_tx1", 32'(tx1), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_start", 32'(busy0), 32'd1);
    collect(0, 4, G0, 29'h10000001, "rst_rel", 0, fz);

    // Table-driven frames
    for (int k = 0; k < 6; k++) begin
      f   = mk_frame(vecs[k].cmd, vecs[k].addr, vecs[k].data, vecs[k].par);
      alt = mk_frame(vecs[k].cmd, vecs[k].addr, vecs[k].alt_data, vecs[k].par);
      run_frame(vecs[k].sel, f, (vecs[k].sel == 0) ? 4 : 1, (vecs[k].sel == 0) ? G0 : G1,
                vecs[k].exp_word, vecs[k].name, vecs[k].hold, alt);
    end

    // T3 back-to-back: start held through S_DONE, with the second frame presented during the first.
    f = mk_frame(2'b01, 16'h0012, 8'hA5, 1'b1);
    frame0 = f;
    start0 = 1'b1;
    @(negedge clk);
    chk("t3_start_lat", 32'(busy0), 32'd1);
    bcnt = 0;
    while (busy0 && bcnt < 256) begin
      frame0 = fz;
      bcnt++;
      @(negedge clk);
    end
    chk("t3_first_busy_len", 32'(bcnt), 32'(FW * 4 + G0));
    chk("t3_first_done", 32'(done0), 32'd1);
    gap = 0;
    while (!busy0 && gap < 10) begin
      if (tx0 === 1'b1) gap++;
      @(negedge clk);
    end
    chk("t3_gap", 32'(gap), 32'd2);
    collect(0, 4, G0, 29'h10000001, "t3_second", 0, fz);

    // T5: reset asserted during bit 7
    f = mk_frame(2'b01, 16'h0012, 8'hA5, 1'b1);
    frame0 = f;
    start0 = 1'b1;
    @(negedge clk);
    chk("t5_start_lat", 32'(busy0), 32'd1);
    start0 = 1'b0;
    for (int i = 0; i < 7 * 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_async_tx", 32'(tx0), 32'd1);
    chk("t5_async_busy", 32'(busy0), 32'd0);
    chk("t5_async_done", 32'(done0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0) dcnt++;
      if (busy0) bcnt++;
    end
    chk("t5_no_done", 32'(dcnt), 32'd0);
    chk("t5_no_busy", 32'(bcnt), 32'd0);
    run_frame(0, f, 4, G0, 29'h14004A97, "t5_clean", 0, f);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
